// File: rtl/mpfe_mem_init_pkg.sv
// Shared types for the MPFE post-reset memory clear sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mpfe_mem_init_pkg;

  localparam int AVM_BURST_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } init_state_t;

endpackage

// File: rtl/mpfe_mem_init.sv
// Clears NUM_WORDS of external memory to FILL with Avalon-MM bursts, then raises init_done.
// Latency: write starts one cycle after reset release; done NUM_WORDS+1 cycles after first write, plus stalls.
// Backpressure: avm_waitrequest freezes all outputs; no timeout.
module mpfe_mem_init
  import mpfe_mem_init_pkg::*;
#(
  parameter int                ADDR_W    = 26,
  parameter int                DATA_W    = 256,
  parameter int                BURST_LEN = 8,
  parameter int                NUM_WORDS = 2**26,
  parameter logic [DATA_W-1:0] FILL      = '0
) (
  input  logic                   bus_clk,
  input  logic                   mpfe_reset,
  input  logic                   init_start,
  output logic                   init_done,
  output logic                   init_busy,
  output logic [ADDR_W-1:0]      avm_address,
  output logic                   avm_write,
  output logic [DATA_W-1:0]      avm_writedata,
  output logic [DATA_W/8-1:0]    avm_byteenable,
  output logic [AVM_BURST_W-1:0] avm_burstcount,
  input  logic                   avm_waitrequest
);

  localparam int BCNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(NUM_WORDS - 1);
  localparam logic [ADDR_W:0]   ALL_WORDS = (ADDR_W + 1)'(NUM_WORDS);

  init_state_t       state;
  logic [BCNT_W-1:0] beat_cnt;
  logic [ADDR_W:0]   word_cnt;
  logic              beat_acc;

  assign avm_writedata  = FILL;
  assign avm_byteenable = '1;
  assign avm_burstcount = AVM_BURST_W'(BURST_LEN);
  assign beat_acc       = avm_write & ~avm_waitrequest;

  always_ff @(posedge bus_clk) begin
    if (mpfe_reset) begin
      state       <= IDLE;
      init_done   <= 1'b0;
      init_busy   <= 1'b0;
      avm_write   <= 1'b0;
      avm_address <= '0;
      beat_cnt    <= '0;
      word_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          state     <= WRITE;
          init_busy <= 1'b1;
          avm_write <= 1'b1;
        end
        WRITE: begin
          // The final beat drops avm_write first; DONE follows one cycle later.
          if (word_cnt == ALL_WORDS) begin
            state     <= DONE;
            init_busy <= 1'b0;
            init_done <= 1'b1;
          end else if (beat_acc) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) begin
              avm_write <= 1'b0;
              beat_cnt  <= '0;
            end else if (beat_cnt == LAST_BEAT) begin
              beat_cnt    <= '0;
              avm_address <= avm_address + ADDR_W'(BURST_LEN);
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (init_start) begin
            state       <= WRITE;
            init_done   <= 1'b0;
            init_busy   <= 1'b1;
            avm_write   <= 1'b1;
            avm_address <= '0;
            beat_cnt    <= '0;
            word_cnt    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpfe_mem_init.sv
// Directed bench for mpfe_mem_init: clean sweep, stalls, restart, ignored start, mid-burst reset, long stall.
// Latency: n/a.
// Backpressure: drives avm_waitrequest from per-test stall probability.
module tb_mpfe_mem_init;

  localparam logic [255:0] FILL_V = {32{8'hA5}};

  logic         bus_clk = 1'b0;
  logic         mpfe_reset;
  logic         init_start;
  logic         init_done;
  logic         init_busy;
  logic [25:0]  avm_address;
  logic         avm_write;
  logic [255:0] avm_writedata;
  logic [31:0]  avm_byteenable;
  logic [6:0]   avm_burstcount;
  logic         avm_waitrequest;

  int nvec = 0;
  int nerr = 0;

  always #5 bus_clk = ~bus_clk;

  mpfe_mem_init #(
    .ADDR_W   (26),
    .DATA_W   (256),
    .BURST_LEN(8),
    .NUM_WORDS(32),
    .FILL     (FILL_V)
  ) dut (
    .bus_clk        (bus_clk),
    .mpfe_reset     (mpfe_reset),
    .init_start     (init_start),
    .init_done      (init_done),
    .init_busy      (init_busy),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_byteenable (avm_byteenable),
    .avm_burstcount (avm_burstcount),
    .avm_waitrequest(avm_waitrequest)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One sweep observed at negedges; returns on done, abort or cycle budget.
  task automatic sweep(input string name, input int stall_pct, input int start_at,
                       input int abort_at, input int hold);
    int  beats, lat, stalls, changes;
    bit  started, fin, pulsed;
    logic [28:0] snap;
    beats = 0; lat = 0; stalls = 0; started = 0; fin = 0; pulsed = 0;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      @(negedge bus_clk);
      init_start = 1'b0;
      if (started) lat++;
      if (init_done) begin
        fin = 1;
        chk({name, "_beats"}, 256'(beats), 256'(32));
        chk({name, "_latency"}, 256'(lat), 256'(33 + stalls));
        chk({name, "_busy_at_done"}, 256'(init_busy), 256'(0));
        chk({name, "_write_at_done"}, 256'(avm_write), 256'(0));
      end else if (avm_write) begin
        if (!started) begin
          started = 1;
          chk({name, "_first_done_low"}, 256'(init_done), 256'(0));
          chk({name, "_first_busy"}, 256'(init_busy), 256'(1));
        end
        if (abort_at >= 0 && beats == abort_at) begin
          mpfe_reset = 1'b1;
          avm_waitrequest = 1'b0;
          fin = 1;
        end else begin
          chk({name, "_addr"}, 256'(avm_address), 256'((beats / 8) * 8));
          chk({name, "_burst"}, 256'(avm_burstcount), 256'(8));
          chk({name, "_data"}, avm_writedata, FILL_V);
          chk({name, "_be"}, 256'(avm_byteenable), 256'(32'hFFFF_FFFF));
          if (hold > 0 && beats == 0) begin
            snap = {avm_write, avm_address, init_busy, init_done};
            changes = 0;
            avm_waitrequest = 1'b1;
            repeat (hold) begin
              @(negedge bus_clk);
              lat++;
              if ({avm_write, avm_address, init_busy, init_done} !== snap) changes++;
            end
            stalls += hold;
            hold = 0;
            chk({name, "_frozen"}, 256'(changes), 256'(0));
          end
          if (start_at >= 0 && beats == start_at && !pulsed) begin
            init_start = 1'b1;
            pulsed = 1;
          end
          avm_waitrequest = ($urandom_range(99) < stall_pct);
          if (avm_waitrequest) stalls++;
          else beats++;
        end
      end else begin
        avm_waitrequest = 1'b0;
      end
    end
    if (!fin) chk({name, "_timeout"}, 256'(0), 256'(1));
  endtask

  initial begin
    int bad;
    mpfe_reset = 1'b1;
    init_start = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (3) @(negedge bus_clk);
    chk("rst_write", 256'(avm_write), 256'(0));
    chk("rst_done", 256'(init_done), 256'(0));
    chk("rst_busy", 256'(init_busy), 256'(0));
    chk("rst_addr", 256'(avm_address), 256'(0));

    // Clean sweep straight out of reset
    mpfe_reset = 1'b0;
    sweep("clean", 0, -1, -1, 0);
    repeat (5) @(negedge bus_clk);
    chk("done_hold", 256'(init_done), 256'(1));
    chk("done_write", 256'(avm_write), 256'(0));

    // Restart from DONE with 50% stalls
    init_start = 1'b1;
    sweep("stall50", 50, -1, -1, 0);

    // Restart, then an init_start mid-sweep must be ignored
    init_start = 1'b1;
    sweep("ign_start", 0, 10, -1, 0);
    bad = 0;
    repeat (40) begin
      @(negedge bus_clk);
      if (avm_write || !init_done) bad++;
    end
    chk("ign_start_once", 256'(bad), 256'(0));

    // Reset after beat 13, then a fresh sweep from address 0
    init_start = 1'b1;
    sweep("abort", 25, -1, 13, 0);
    @(negedge bus_clk);
    chk("abort_write", 256'(avm_write), 256'(0));
    chk("abort_busy", 256'(init_busy), 256'(0));
    chk("abort_addr", 256'(avm_address), 256'(0));
    mpfe_reset = 1'b0;
    sweep("after_abort", 0, -1, -1, 0);

    // Waitrequest held for 1000 cycles on beat 0
    init_start = 1'b1;
    sweep("hold1000", 0, -1, -1, 1000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
